note_tone_mixer: RTL and testbench

//  Downstream of the music controller: turns its 7-bit note enable (one bit per pitch C4..B4)

---
 rtl/note_tone_mixer.sv | 148 ++++++++++++++
 tb/tb_note_tone_mixer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/note_tone_mixer.sv
// Seven-voice square-wave synth: per-voice phase counters, sequential
// 7-cycle mixer with 16-bit saturation, valid/ready sample output.
module note_tone_mixer #(
    parameter int SAMPLE_DIV = 1042,
    parameter int AMP        = 4096,
    parameter int HALF_P0    = 92,
    parameter int HALF_P1    = 82,
    parameter int HALF_P2    = 73,
    parameter int HALF_P3    = 69,
    parameter int HALF_P4    = 61,
    parameter int HALF_P5    = 55,
    parameter int HALF_P6    = 49
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [6:0]  iMusicEnb,
    input  logic        iNoteRst,
    input  logic        iReady,
    output logic [15:0] oSample,
    output logic        oValid,
    output logic        oFlashValid,
    output logic        oOverrun
);

    typedef enum logic [1:0] {IDLE, RUN, MIX, HOLD} state_t;

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic signed [18:0] AMP_S = 19'(AMP);
    localparam logic [6:0][15:0] HALF_M1 = {
        16'(HALF_P6 - 1), 16'(HALF_P5 - 1), 16'(HALF_P4 - 1),
        16'(HALF_P3 - 1), 16'(HALF_P2 - 1), 16'(HALF_P1 - 1),
        16'(HALF_P0 - 1)
    };

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        div_cnt;
    logic               tick;
    logic [6:0][15:0]   ph;
    logic [6:0]         pol;
    logic [6:0]         enb_q;
    logic [2:0]         k;
    logic signed [18:0] acc;
    logic signed [18:0] term;
    logic signed [18:0] acc_sum;
    logic               mix_last;

    function automatic logic [15:0] sat16(input logic signed [18:0] v);
        if (v > 19'sd32767)
            return 16'h7fff;
        else if (v < -19'sd32768)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

    assign tick     = (state != IDLE) && (div_cnt == DIV_LAST);
    assign mix_last = (k == 3'd6);
    assign term     = enb_q[k] ? (pol[k] ? AMP_S : -AMP_S) : '0;
    assign acc_sum  = acc + term;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Note restart overrides every other transition
    always_comb begin
        state_nxt = state;
        if (iNoteRst) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nxt = RUN;
                RUN:  if (tick) state_nxt = MIX;
                MIX:  if (mix_last) state_nxt = HOLD;
                HOLD: if (iReady && oValid) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        oFlashValid = (state != IDLE);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST || iNoteRst) begin
            div_cnt  <= '0;
            ph       <= '0;
            pol      <= '0;
            enb_q    <= '0;
            k        <= '0;
            acc      <= '0;
            oSample  <= '0;
            oValid   <= 1'b0;
            oOverrun <= 1'b0;
        end else begin
            if (state == IDLE)
                div_cnt <= '0;
            else
                div_cnt <= tick ? '0 : div_cnt + 16'd1;

            // Phases advance on every tick, even when the sample is dropped
            if (tick) begin
                for (int i = 0; i < 7; i++) begin
                    if (!iMusicEnb[i]) begin
                        ph[i]  <= '0;
                        pol[i] <= 1'b0;
                    end else if (ph[i] == HALF_M1[i]) begin
                        ph[i]  <= '0;
                        pol[i] <= ~pol[i];
                    end else begin
                        ph[i]  <= ph[i] + 16'd1;
                    end
                end
            end

            unique case (state)
                RUN: begin
                    if (tick) begin
                        enb_q <= iMusicEnb;
                        acc   <= '0;
                        k     <= '0;
                    end
                end
                MIX: begin
                    acc <= acc_sum;
                    k   <= mix_last ? 3'd0 : k + 3'd1;
                    if (mix_last) begin
                        oSample <= sat16(acc_sum);
                        oValid  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (tick)
                        oOverrun <= 1'b1;
                    if (iReady && oValid)
                        oValid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_note_tone_mixer.sv
// Directed bench for note_tone_mixer: table of enable patterns plus
// hand-written sequences for timing, overrun, restart and reset cases.
module tb_note_tone_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  enb = '0;
    logic        note_rst = 1'b0;
    logic        ready = 1'b1;
    logic [15:0] sample, s_sample;
    logic        valid, flash, ovr;
    logic        s_valid, s_flash, s_ovr;

    int tests = 0;
    int fails = 0;
    int cyc;
    int s0;
    int bad;
    int got [277];

    typedef struct {
        logic [6:0] enb;
        int         exp;
        int         exp_sat;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    note_tone_mixer #(.SAMPLE_DIV(16), .AMP(4096)) dut (
        .iCLK(clk), .iRST(rst), .iMusicEnb(enb), .iNoteRst(note_rst),
        .iReady(ready), .oSample(sample), .oValid(valid),
        .oFlashValid(flash), .oOverrun(ovr)
    );

    // Large amplitude and short half-periods to reach both clamps
    note_tone_mixer #(
        .SAMPLE_DIV(16), .AMP(20000),
        .HALF_P0(2), .HALF_P1(2), .HALF_P2(2), .HALF_P3(2),
        .HALF_P4(2), .HALF_P5(2), .HALF_P6(2)
    ) dut_sat (
        .iCLK(clk), .iRST(rst), .iMusicEnb(enb), .iNoteRst(note_rst),
        .iReady(ready), .oSample(s_sample), .oValid(s_valid),
        .oFlashValid(s_flash), .oOverrun(s_ovr)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < budget);
        if (!valid) begin
            tests++;
            fails++;
            $display("FAIL wait_valid: no oValid after %0d cycles", n);
        end
    endtask

    task automatic note_reset(input logic [6:0] e);
        @(negedge clk);
        note_rst = 1'b1;
        enb = e;
        @(negedge clk);
        note_rst = 1'b0;
    endtask

    function automatic int sv(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{7'b0000001,  -4096, -20000};
        vecs[1] = '{7'b1111111, -28672, -32768};
        vecs[2] = '{7'b0000000,      0,      0};
        vecs[3] = '{7'b1010101, -16384, -32768};
        vecs[4] = '{7'b0001000,  -4096, -20000};
        vecs[5] = '{7'b0110000,  -8192, -32768};

        rst = 1'b1;
        @(negedge clk);
        check("reset_state", int'({sample, valid, flash, ovr}), 0);
        check("reset_state_sat", int'({s_sample, s_valid, s_flash, s_ovr}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("flash_after_rst", int'(flash), 1);

        for (int i = 0; i < 6; i++) begin
            note_reset(vecs[i].enb);
            wait_valid(40, cyc);
            check($sformatf("vec%0d_sample", i), sv(sample), vecs[i].exp);
            check($sformatf("vec%0d_sat", i), sv(s_sample), vecs[i].exp_sat);
            if (i == 0)
                check("latency", cyc, 24);
        end

        // Second sample: main DUT unchanged, saturating DUT flips to +clamp
        note_reset(7'b1111111);
        wait_valid(40, cyc);
        wait_valid(40, cyc);
        check("all_on_2nd", sv(sample), -28672);
        check("sat_pos", sv(s_sample), 32767);

        // Single voice C4: 92 samples per half period
        note_reset(7'b0000001);
        for (int n = 1; n <= 276; n++) begin
            wait_valid(40, cyc);
            got[n] = sv(sample);
        end
        check("c4_s1", got[1], -4096);
        check("c4_s91", got[91], -4096);
        check("c4_s92", got[92], 4096);
        check("c4_s183", got[183], 4096);
        check("c4_s184", got[184], -4096);
        check("c4_s275", got[275], -4096);
        check("c4_s276", got[276], 4096);
        check("no_overrun", int'(ovr), 0);

        // Codec stall across a tick
        ready = 1'b0;
        note_reset(7'b0000001);
        wait_valid(40, cyc);
        s0 = sv(sample);
        check("stall_sample", s0, -4096);
        bad = 0;
        for (int n = 0; n < 42; n++) begin
            @(negedge clk);
            if (!valid || sv(sample) != s0)
                bad++;
        end
        check("stall_hold_bad_cycles", bad, 0);
        check("overrun_set", int'(ovr), 1);
        ready = 1'b1;
        @(negedge clk);
        check("stall_handshake", int'(valid), 0);
        wait_valid(40, cyc);
        check("post_stall_sample", sv(sample), -4096);
        check("overrun_sticky", int'(ovr), 1);

        // Note restart while a sample is pending
        ready = 1'b0;
        wait_valid(40, cyc);
        note_rst = 1'b1;
        enb = 7'b0000101;
        @(negedge clk);
        check("nrst_valid", int'(valid), 0);
        check("nrst_overrun", int'(ovr), 0);
        check("nrst_flash", int'(flash), 0);
        note_rst = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        check("nrst_flash_back", int'(flash), 1);
        wait_valid(40, cyc);
        check("nrst_first_sample", sv(sample), -8192);

        // Enable change during MIX applies to the next sample only
        note_reset(7'b0000001);
        repeat (18) @(negedge clk);
        enb = 7'b0001001;
        wait_valid(40, cyc);
        check("mix_toggle_cur", sv(sample), -4096);
        wait_valid(40, cyc);
        check("mix_toggle_next", sv(sample), -8192);

        // Asynchronous reset in HOLD
        ready = 1'b0;
        wait_valid(40, cyc);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", int'({sample, valid, flash, ovr}), 0);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        check("async_rst_flash", int'(flash), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
